// File: rtl/seq_pkg.sv
// Shared definitions for the serial frame generator and its companion sequence detector bench.
package seq_pkg;

  localparam int unsigned DefaultWidth = 10;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StSend = 2'd1,
    StDone = 2'd2
  } state_t;

endpackage

// File: rtl/bit_counter.sv
// Modulo-N bit index counter with synchronous clear and a terminal-count flag.
module bit_counter #(
  parameter int unsigned N = 10
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clr,
  input  logic                 en,
  output logic [$clog2(N)-1:0] cnt,
  output logic                 last
);

  localparam int unsigned CW = $clog2(N);

  logic [CW-1:0] cnt_q;

  assign cnt  = cnt_q;
  assign last = (cnt_q == CW'(N - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (en) begin
      cnt_q <= last ? '0 : cnt_q + CW'(1);
    end
  end

endmodule

// File: rtl/seq_gen.sv
// Parallel-to-serial frame generator with optional back-to-back repeat, abort and frame count.
module seq_gen
  import seq_pkg::*;
#(
  parameter int unsigned WIDTH     = DefaultWidth,
  parameter bit          LSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] data,
  input  logic             rep,
  input  logic             abort,
  output logic             ready,
  output logic             o,
  output logic             o_valid,
  output logic             done,
  output logic [7:0]       frames
);

  localparam int unsigned CW = $clog2(WIDTH);

  state_t           state_q;
  logic [WIDTH-1:0] word_q;
  logic [WIDTH-1:0] shift_q;
  logic             rep_q;
  logic             o_q;
  logic             o_valid_q;
  logic             done_q;
  logic [7:0]       frames_q;
  logic [CW-1:0]    idx;
  logic             idx_last;
  logic             idx_clr;
  logic             idx_en;

  function automatic logic first_bit(input logic [WIDTH-1:0] w);
    return LSB_FIRST ? w[0] : w[WIDTH-1];
  endfunction

  // Drops the bit just presented so the next one sits at the head.
  function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] w);
    return LSB_FIRST ? (w >> 1) : (w << 1);
  endfunction

  assign idx_clr = (state_q != StSend) || abort;
  assign idx_en  = (state_q == StSend);

  bit_counter #(
    .N(WIDTH)
  ) u_bit_counter (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (idx_clr),
    .en   (idx_en),
    .cnt  (idx),
    .last (idx_last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      word_q    <= '0;
      shift_q   <= '0;
      rep_q     <= 1'b0;
      o_q       <= 1'b0;
      o_valid_q <= 1'b0;
      done_q    <= 1'b0;
      frames_q  <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            word_q    <= data;
            shift_q   <= advance(data);
            rep_q     <= rep;
            o_q       <= first_bit(data);
            o_valid_q <= 1'b1;
            state_q   <= StSend;
          end
        end
        StSend: begin
          if (abort) begin
            o_q       <= 1'b0;
            o_valid_q <= 1'b0;
            state_q   <= StIdle;
          end else if (idx_last) begin
            frames_q <= frames_q + 8'd1;
            if (rep_q) begin
              o_q     <= first_bit(word_q);
              shift_q <= advance(word_q);
            end else begin
              o_q       <= 1'b0;
              o_valid_q <= 1'b0;
              done_q    <= 1'b1;
              state_q   <= StDone;
            end
          end else begin
            o_q     <= first_bit(shift_q);
            shift_q <= advance(shift_q);
          end
        end
        StDone: begin
          done_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: begin
          o_q       <= 1'b0;
          o_valid_q <= 1'b0;
          done_q    <= 1'b0;
          state_q   <= StIdle;
        end
      endcase
    end
  end

  assign ready   = (state_q == StIdle);
  assign o       = o_q;
  assign o_valid = o_valid_q;
  assign done    = done_q;
  assign frames  = frames_q;

endmodule

// File: tb/tb_seq_gen.sv
// Bench for seq_gen: queue-based output model checked every cycle, plus directed literal checks.
module tb_seq_gen;

  localparam int W = 10;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [W-1:0] data;
  logic         rep;
  logic         abort;

  logic       ready_l, o_l, o_valid_l, done_l;
  logic [7:0] frames_l;
  logic       ready_m, o_m, o_valid_m, done_m;
  logic [7:0] frames_m;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  seq_gen #(
    .WIDTH    (W),
    .LSB_FIRST(1'b1)
  ) dut_lsb (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .data   (data),
    .rep    (rep),
    .abort  (abort),
    .ready  (ready_l),
    .o      (o_l),
    .o_valid(o_valid_l),
    .done   (done_l),
    .frames (frames_l)
  );

  seq_gen #(
    .WIDTH    (W),
    .LSB_FIRST(1'b0)
  ) dut_msb (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .data   (data),
    .rep    (rep),
    .abort  (abort),
    .ready  (ready_m),
    .o      (o_m),
    .o_valid(o_valid_m),
    .done   (done_m),
    .frames (frames_m)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: every future output cycle is an entry in a queue; empty queue means idle.
  typedef struct {
    logic ol;
    logic om;
    logic dn;
    logic last;
  } ent_t;

  ent_t         q[$];
  ent_t         popped;
  logic [W-1:0] m_word;
  logic         m_rep;
  logic [7:0]   m_frames = 8'd0;

  task automatic fill(input logic [W-1:0] w);
    for (int k = 0; k < W; k++) q.push_back('{w[k], w[W-1-k], 1'b0, (k == W - 1)});
  endtask

  always @(posedge clk) begin
    if (rst_n) begin
      if (q.size() == 0) begin
        if (start) begin
          m_word = data;
          m_rep  = rep;
          fill(data);
          if (!rep) q.push_back('{1'b0, 1'b0, 1'b1, 1'b0});
        end
      end else if (!q[0].dn && abort) begin
        q.delete();
      end else begin
        popped = q.pop_front();
        if (popped.last) begin
          m_frames = m_frames + 8'd1;
          if (m_rep) fill(m_word);
        end
      end
    end
  end

  always @(negedge rst_n) begin
    q.delete();
    m_frames = 8'd0;
  end

  always @(negedge clk) begin
    logic eol, eom, ev, ed;
    eol = 1'b0; eom = 1'b0; ev = 1'b0; ed = 1'b0;
    if (q.size() != 0) begin
      eol = q[0].ol;
      eom = q[0].om;
      ev  = !q[0].dn;
      ed  = q[0].dn;
    end
    check("o_lsb", {31'd0, o_l}, {31'd0, eol});
    check("o_msb", {31'd0, o_m}, {31'd0, eom});
    check("o_valid", {30'd0, o_valid_l, o_valid_m}, {30'd0, ev, ev});
    check("done", {30'd0, done_l, done_m}, {30'd0, ed, ed});
    check("ready", {30'd0, ready_l, ready_m}, {30'd0, q.size() == 0, q.size() == 0});
    check("frames", {16'd0, frames_l, frames_m}, {16'd0, m_frames, m_frames});
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Captures W consecutive cycles of both streams, first bit in the MSB.
  task automatic collect(output logic [W-1:0] sl, output logic [W-1:0] sm);
    for (int i = 0; i < W; i++) begin
      sl[W-1-i] = o_l;
      sm[W-1-i] = o_m;
      tick();
    end
  endtask

  localparam logic [W-1:0] D      = 10'b0001101011;
  localparam logic [W-1:0] LsbSeq = 10'b1101011000;
  localparam logic [W-1:0] MsbSeq = 10'b0001101011;

  logic [W-1:0] sl, sm, pat;
  int           errs;

  initial begin
    rst_n = 1'b0; start = 1'b0; data = '0; rep = 1'b0; abort = 1'b0;
    pat = LsbSeq;
    #2;
    check("reset_ready", {31'd0, ready_l}, 32'd1);
    check("reset_frames", {24'd0, frames_l}, 32'd0);
    tick(); tick();

    // Single frame, start offered together with reset release.
    rst_n = 1'b1; start = 1'b1; data = D; rep = 1'b0;
    tick();
    start = 1'b0;
    collect(sl, sm);
    check("frame_lsb_stream", {22'd0, sl}, {22'd0, LsbSeq});
    check("frame_msb_stream", {22'd0, sm}, {22'd0, MsbSeq});
    check("frame_done", {31'd0, done_l}, 32'd1);
    check("frame_count", {24'd0, frames_l}, 32'd1);
    tick();
    check("frame_ready", {31'd0, ready_l}, 32'd1);

    // Repeat mode: three back-to-back copies, then abort.
    start = 1'b1; rep = 1'b1;
    tick();
    start = 1'b0; rep = 1'b0;
    errs = 0;
    for (int i = 0; i < 3 * W; i++) begin
      if (o_l !== pat[W-1-(i % W)] || o_valid_l !== 1'b1 || done_l !== 1'b0) errs++;
      tick();
    end
    check("repeat_stream_errs", errs, 32'd0);
    check("repeat_count", {24'd0, frames_l}, 32'd4);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("repeat_abort_valid", {31'd0, o_valid_l}, 32'd0);
    check("repeat_abort_frames", {24'd0, frames_l}, 32'd4);

    // Abort while bit index 4 is on o.
    start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick(); tick(); tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_o", {30'd0, o_l, o_valid_l}, 32'd0);
    check("abort_done", {31'd0, done_l}, 32'd0);
    check("abort_ready", {31'd0, ready_l}, 32'd1);
    check("abort_frames", {24'd0, frames_l}, 32'd4);
    tick();
    check("abort_no_done", {31'd0, done_l}, 32'd0);

    // Start with all-ones data during a frame must be ignored.
    start = 1'b1; data = D;
    tick();
    start = 1'b0;
    for (int i = 0; i < W; i++) begin
      sl[W-1-i] = o_l;
      if (i == 2) begin start = 1'b1; data = 10'h3FF; end
      if (i == 3) start = 1'b0;
      tick();
    end
    check("ignore_start_stream", {22'd0, sl}, {22'd0, LsbSeq});
    check("ignore_start_count", {24'd0, frames_l}, 32'd5);
    tick();
    check("ignore_start_idle", {30'd0, ready_l, o_valid_l}, 32'd2);

    // Reset mid-frame, then a clean frame.
    start = 1'b1; data = D;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    check("pre_reset_o", {31'd0, o_l}, 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check("async_reset_o", {30'd0, o_l, o_valid_l}, 32'd0);
    check("async_reset_frames", {24'd0, frames_l}, 32'd0);
    check("async_reset_ready", {31'd0, ready_l}, 32'd1);
    tick();
    rst_n = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    collect(sl, sm);
    check("post_reset_stream", {22'd0, sl}, {22'd0, LsbSeq});
    check("post_reset_done", {31'd0, done_l}, 32'd1);
    check("post_reset_count", {24'd0, frames_l}, 32'd1);
    tick();

    // 255 repeat wraps take the count from 1 through 255 to 0.
    start = 1'b1; rep = 1'b1;
    tick();
    start = 1'b0; rep = 1'b0;
    for (int i = 0; i < 255 * W; i++) tick();
    check("frames_wrap", {24'd0, frames_l}, 32'd0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    tick();
    check("final_idle", {31'd0, ready_l}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/seq_gen.md
SEQ_GEN -- requirements
Module: seq_gen

Interface
REQ-001 The module SHALL have parameter WIDTH, default 10, setting the frame length in bits (legal range 2..32).
REQ-002 The module SHALL have parameter LSB_FIRST, default 1, where 1 means bit 0 is sent first and 0 means bit WIDTH-1 is sent first.
REQ-003 The module SHALL have port clk, input, 1 bit: the single clock, with all state updating on its rising edge.
REQ-004 The module SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The module SHALL have port start, input, 1 bit: request to send the frame on data.
REQ-006 The module SHALL have port data, input, WIDTH bits: the parallel frame, sampled only when start is accepted.
REQ-007 The module SHALL have port rep, input, 1 bit: continuous-repeat request, sampled only when start is accepted.
REQ-008 The module SHALL have port abort, input, 1 bit: terminate the frame in progress.
REQ-009 The module SHALL have port ready, output, 1 bit: high when start can be accepted.
REQ-010 The module SHALL have port o, output, 1 bit: the registered serial bit stream feeding the sequence detector input.
REQ-011 The module SHALL have port o_valid, output, 1 bit: high while o carries a frame bit.
REQ-012 The module SHALL have port done, output, 1 bit: one-cycle pulse marking normal frame completion.
REQ-013 The module SHALL have port frames, output, 8 bits: count of completed frames.

Function
REQ-014 The FSM SHALL have exactly the states IDLE, SEND and DONE.
REQ-015 ready SHALL equal (state == IDLE), decoded combinationally from state.
REQ-016 In IDLE, when start=1 at a rising edge, the module SHALL capture data into a shift register, latch rep, clear the bit index and enter SEND.
REQ-017 start SHALL be ignored whenever ready=0.
REQ-018 The first frame bit SHALL appear on o, with o_valid=1, in the cycle after start is accepted (latency 1).
REQ-019 In SEND, o SHALL present one bit per clock in the order selected by LSB_FIRST, and the bit index SHALL count 0..WIDTH-1.
REQ-020 At index WIDTH-1 with latched rep=1, the index SHALL wrap to 0, the shift register SHALL reload the captured word, and the stream SHALL continue with no gap cycle.
REQ-021 At index WIDTH-1 with latched rep=0, the FSM SHALL enter DONE.
REQ-022 In DONE, the module SHALL drive done=1, o=0 and o_valid=0 for exactly one cycle, and the FSM SHALL then return to IDLE.
REQ-023 frames SHALL increment by 1 on each frame completion, meaning each DONE entry and each repeat wrap, and SHALL wrap from 255 to 0.
REQ-024 An abort sampled in SEND SHALL return the FSM to IDLE at the next edge with o=0, o_valid=0, no done pulse and no increment of frames.
REQ-025 An abort coinciding with the last bit or a repeat wrap SHALL take priority: IDLE, no done, no count.
REQ-026 An abort sampled in IDLE or DONE SHALL have no effect.
REQ-027 Outside SEND, o SHALL be 0.
REQ-028 The index counter SHALL be $clog2(WIDTH) bits wide and SHALL never exceed WIDTH-1.

Reset
REQ-029 While rst_n=0, the module SHALL immediately set state=IDLE, o=0, o_valid=0, done=0, frames=0, index=0, shift register=0 and latched rep=0, and ready SHALL read 1.
REQ-030 A reset asserted mid-frame SHALL discard the frame, produce no done pulse, and leave no residual bits after release.
REQ-031 The first start SHALL be accepted at the first rising edge after rst_n rises.

Structure
REQ-032 The state encodings (IDLE=2'd0, SEND=2'd1, DONE=2'd2) and the default WIDTH SHALL reside in a shared package/header, seq_pkg, that is also used by the sequence detector bench.
REQ-033 The index counter, including its wrap and terminal-count flag, SHALL be a sub-module named bit_counter with parameter N and ports clk, rst_n, clr, en, cnt, last.

Verification
REQ-034 Scenario: data=10'b0001101011, rep=0, one-cycle start -> o=1,1,0,1,0,1,1,0,0,0 on cycles 1..10 with o_valid=1, done=1 on cycle 11, frames=1, ready=1 on cycle 12.
REQ-035 Scenario: same data with rep=1 -> the 10-bit pattern repeats back-to-back for 30 cycles with no gap, frames=3, no done pulse.
REQ-036 Scenario: abort=1 while bit index 4 is on o -> o=0 and o_valid=0 the next cycle, no done, frames unchanged, ready=1.
REQ-037 Scenario: start pulsed with data=10'h3FF during a frame -> the current frame is uncorrupted and the second start is ignored.
REQ-038 Scenario: rst_n pulsed low mid-frame -> outputs are 0 asynchronously, frames=0, and a new start after release sends a full correct frame.
REQ-039 Scenario: LSB_FIRST=0 with data=10'b0001101011 -> o=0,0,0,1,1,0,1,0,1,1.
